word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer_pkg.sv | 18 +
 rtl/word_serializer_lane_select.sv | 31 +++
 rtl/word_serializer.sv | 86 ++++++++
 tb/tb_word_serializer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the word serializer.
// Holds the FSM state encoding and a helper that sizes the lane index.
package word_serializer_pkg;

    localparam int DEFAULT_WORD_W = 32;
    localparam int DEFAULT_LANE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // A lane index is at least one bit wide, even when a word has a single lane.
    function automatic int calc_iw(input int lanes);
        return (lanes <= 2) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/word_serializer_lane_select.sv
// Combinational lane picker: returns bits [idx*LANE_W +: LANE_W] of a word.
// Out-of-range indices (non power-of-two lane counts) return zero.
module lane_select
    import word_serializer_pkg::*;
#(
    parameter  int WORD_W = DEFAULT_WORD_W,
    parameter  int LANE_W = DEFAULT_LANE_W,
    localparam int LANES  = WORD_W / LANE_W,
    localparam int IW     = calc_iw(LANES)
) (
    input  logic [WORD_W-1:0] word_i,
    input  logic [IW-1:0]     idx_i,
    output logic [LANE_W-1:0] lane_o
);

    logic [LANE_W-1:0] lanes [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lanes[gi] = word_i[gi*LANE_W +: LANE_W];
    end

    always_comb begin
        lane_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (idx_i == IW'(i)) begin
                lane_o = lanes[i];
            end
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Splits a WORD_W word into count lanes of LANE_W bits, msb- or lsb-first,
// with valid/ready handshakes on both sides and zero-bubble word chaining.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter  int WORD_W = DEFAULT_WORD_W,
    parameter  int LANE_W = DEFAULT_LANE_W,
    localparam int LANES  = WORD_W / LANE_W,
    localparam int IW     = calc_iw(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [IW-1:0]     in_count,
    input  logic              in_msb_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [IW-1:0]     out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [IW-1:0] TOP_LANE = IW'(LANES - 1);

    state_e            state_q;
    logic [WORD_W-1:0] word_q;
    logic              msb_q;
    logic [IW-1:0]     count_q;
    logic [IW-1:0]     cnt_q;

    logic [IW-1:0]     last_cnt;
    logic              in_fire;
    logic              out_fire;

    // A stored count of zero stands for a full word of LANES lanes.
    assign last_cnt  = (count_q == '0) ? TOP_LANE : (count_q - IW'(1));

    assign busy      = (state_q == EMIT);
    assign out_valid = busy;
    assign out_last  = busy && (cnt_q == last_cnt);
    assign out_idx   = msb_q ? (TOP_LANE - cnt_q) : cnt_q;

    assign in_ready  = rst_n && (!busy || (out_last && out_ready));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    lane_select #(
        .WORD_W (WORD_W),
        .LANE_W (LANE_W)
    ) u_lane_select (
        .word_i (word_q),
        .idx_i  (out_idx),
        .lane_o (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            msb_q   <= 1'b0;
            count_q <= '0;
            cnt_q   <= '0;
        end else begin
            // Loading a new word takes priority; it also covers the
            // back-to-back case where the last lane leaves this cycle.
            if (in_fire) begin
                state_q <= EMIT;
                word_q  <= in_data;
                msb_q   <= in_msb_first;
                count_q <= in_count;
                cnt_q   <= '0;
            end else if (out_fire) begin
                if (out_last) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q   <= cnt_q + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (WORD_W=32, LANE_W=8).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_count;
    logic        in_msb_first;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    word_serializer #(
        .WORD_W (32),
        .LANE_W (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_count     (in_count),
        .in_msb_first (in_msb_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one presented lane, then advances to the next falling edge.
    task automatic beat(input string tag, input logic [7:0] d, input logic [1:0] idx,
                        input logic last, input logic rdy);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".busy"},  32'(busy),      32'd1);
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".idx"},   32'(out_idx),   32'(idx));
        check({tag, ".last"},  32'(out_last),  32'(last));
        check({tag, ".inrdy"}, 32'(in_ready),  32'(rdy));
        $display("beat %s: data=%02h idx=%0d last=%0b in_ready=%0b", tag, out_data, out_idx, out_last, in_ready);
        @(negedge clk);
    endtask

    // Offers one word for a single cycle (block must be idle).
    task automatic send(input string tag, input logic [31:0] d, input logic [1:0] cnt, input logic msb);
        in_valid     = 1'b1;
        in_data      = d;
        in_count     = cnt;
        in_msb_first = msb;
        #1;
        check({tag, ".accept"}, 32'(in_ready),  32'd1);
        check({tag, ".nolat"},  32'(out_valid), 32'd0);
        $display("send %s: data=%08h count=%0d msb_first=%0b", tag, d, cnt, msb);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_count = 2'd3;
    endtask

    task automatic expect_idle(input string tag);
        #1;
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".idle_busy"},  32'(busy),      32'd0);
        check({tag, ".idle_rdy"},   32'(in_ready),  32'd1);
        $display("idle %s: busy=%0b out_valid=%0b", tag, busy, out_valid);
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_count     = '0;
        in_msb_first = 1'b0;
        out_ready    = 1'b1;

        #3;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.last",  32'(out_last),  32'd0);
        check("rst.busy",  32'(busy),      32'd0);
        check("rst.data",  32'(out_data),  32'd0);
        check("rst.idx",   32'(out_idx),   32'd0);
        check("rst.inrdy", 32'(in_ready),  32'd0);
        $display("reset: in_ready=%0b busy=%0b", in_ready, busy);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_idle("post_rst");

        // Full word, msb first
        send("msb", 32'h0102_0304, 2'd0, 1'b1);
        beat("msb0", 8'h01, 2'd3, 1'b0, 1'b0);
        beat("msb1", 8'h02, 2'd2, 1'b0, 1'b0);
        beat("msb2", 8'h03, 2'd1, 1'b0, 1'b0);
        beat("msb3", 8'h04, 2'd0, 1'b1, 1'b1);
        expect_idle("msb");

        // Full word, lsb first
        send("lsb", 32'h0102_0304, 2'd0, 1'b0);
        beat("lsb0", 8'h04, 2'd0, 1'b0, 1'b0);
        beat("lsb1", 8'h03, 2'd1, 1'b0, 1'b0);
        beat("lsb2", 8'h02, 2'd2, 1'b0, 1'b0);
        beat("lsb3", 8'h01, 2'd3, 1'b1, 1'b1);
        expect_idle("lsb");

        // Partial counts
        send("cnt2", 32'h1111_2222, 2'd2, 1'b0);
        beat("cnt2_0", 8'h22, 2'd0, 1'b0, 1'b0);
        beat("cnt2_1", 8'h22, 2'd1, 1'b1, 1'b1);
        expect_idle("cnt2");
        send("cnt1", 32'h1111_2222, 2'd1, 1'b1);
        beat("cnt1_0", 8'h11, 2'd3, 1'b1, 1'b1);
        expect_idle("cnt1");

        // Backpressure: out_ready 1,0,0,1,1,1
        send("bp", 32'hA1B2_C3D4, 2'd0, 1'b1);
        out_ready = 1'b1; beat("bp0", 8'hA1, 2'd3, 1'b0, 1'b0);
        out_ready = 1'b0; beat("bp1", 8'hB2, 2'd2, 1'b0, 1'b0);
        out_ready = 1'b0; beat("bp2", 8'hB2, 2'd2, 1'b0, 1'b0);
        out_ready = 1'b1; beat("bp3", 8'hB2, 2'd2, 1'b0, 1'b0);
        out_ready = 1'b1; beat("bp4", 8'hC3, 2'd1, 1'b0, 1'b0);
        out_ready = 1'b1; beat("bp5", 8'hD4, 2'd0, 1'b1, 1'b1);
        expect_idle("bp");

        // Back-to-back words, in_valid held; second word staged while the first drains
        in_valid     = 1'b1;
        in_data      = 32'h1111_1111;
        in_count     = 2'd0;
        in_msb_first = 1'b0;
        #1;
        check("b2b.accept", 32'(in_ready), 32'd1);
        $display("send b2b first: data=%08h", in_data);
        @(negedge clk);
        in_data = 32'h0000_2222;
        beat("b2b0", 8'h11, 2'd0, 1'b0, 1'b0);
        beat("b2b1", 8'h11, 2'd1, 1'b0, 1'b0);
        beat("b2b2", 8'h11, 2'd2, 1'b0, 1'b0);
        beat("b2b3", 8'h11, 2'd3, 1'b1, 1'b1);
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        beat("b2b4", 8'h22, 2'd0, 1'b0, 1'b0);
        beat("b2b5", 8'h22, 2'd1, 1'b0, 1'b0);
        beat("b2b6", 8'h00, 2'd2, 1'b0, 1'b0);
        beat("b2b7", 8'h00, 2'd3, 1'b1, 1'b1);
        expect_idle("b2b");

        // Asynchronous reset mid-word, then a clean new word
        send("ar", 32'h0102_0304, 2'd0, 1'b1);
        beat("ar0", 8'h01, 2'd3, 1'b0, 1'b0);
        beat("ar1", 8'h02, 2'd2, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.last",  32'(out_last),  32'd0);
        check("ar.busy",  32'(busy),      32'd0);
        check("ar.data",  32'(out_data),  32'd0);
        check("ar.idx",   32'(out_idx),   32'd0);
        check("ar.inrdy", 32'(in_ready),  32'd0);
        $display("async reset mid-word: out_valid=%0b busy=%0b", out_valid, busy);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send("ar_new", 32'h0000_3333, 2'd2, 1'b1);
        beat("ar_new0", 8'h00, 2'd3, 1'b0, 1'b0);
        beat("ar_new1", 8'h00, 2'd2, 1'b1, 1'b1);
        expect_idle("ar_new");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
